seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset, both sampled on the rising edge of fsm_clk.
REQ-002 Parameter PAT_W SHALL default to 5 and set the pattern length in bits; legal range 2..16.
REQ-003 Parameter CNT_W SHALL default to 8 and set the match-counter width; legal range 1..16.
REQ-004 Parameter DEF_PAT SHALL default to 5'b10101 and set the pattern loaded at reset.
REQ-005 Port fsm_clk SHALL be input, 1 bit, the FSM clock.
REQ-006 Port rst_n SHALL be input, 1 bit, the synchronous active-low reset.
REQ-007 Port din SHALL be input, 1 bit, the serial data bit.
REQ-008 Port din_vld SHALL be input, 1 bit; din is consumed only on edges where din_vld=1.
REQ-009 Port overlap SHALL be input, 1 bit; 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-010 Port pat_load SHALL be input, 1 bit, a strobe that loads pat_in.
REQ-011 Port pat_in SHALL be input, PAT_W bits; bit PAT_W-1 is the first-received bit and bit 0 is the last-received bit.
REQ-012 Port cnt_clr SHALL be input, 1 bit, a strobe that clears match_cnt.
REQ-013 Port seq_det SHALL be a registered output, 1 bit, the detection pulse.
REQ-014 Port match_cnt SHALL be a registered output, CNT_W bits, the saturating detection count.
REQ-015 Port fill SHALL be a registered output, $clog2(PAT_W+1) bits, giving the number of valid history bits (0..PAT_W).

Function
REQ-016 On each edge with din_vld=1, history SHALL shift left with din entering bit 0, and fill SHALL increment, saturating at PAT_W.
REQ-017 A match SHALL occur on an edge where din_vld=1, the post-shift fill equals PAT_W, and the post-shift history equals the pattern register.
REQ-018 seq_det SHALL be 1 for exactly one cycle, beginning at the edge that samples the final pattern bit; otherwise it SHALL be 0.
REQ-019 Edges with din_vld=0 SHALL leave history and fill unchanged, and SHALL force seq_det to 0.
REQ-020 When overlap=1, fill SHALL remain at PAT_W after a match, so trailing bits can start the next match.
REQ-021 When overlap=0, fill SHALL be set to 0 on a match edge, so the next match needs PAT_W fresh bits.
REQ-022 overlap SHALL be sampled on every din_vld edge; a mode change affects only the current and later edges.
REQ-023 On a pat_load edge, the pattern register SHALL take pat_in, history and fill SHALL clear, and seq_det SHALL be 0; din is ignored that cycle.
REQ-024 Priority SHALL be rst_n, then pat_load, then din_vld.
REQ-025 match_cnt SHALL increment on each match and saturate at 2^CNT_W-1, never wrapping.
REQ-026 cnt_clr SHALL set match_cnt to 0; if cnt_clr and a match occur on the same edge, match_cnt SHALL become 1.
REQ-027 pat_load SHALL NOT alter match_cnt.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL set pattern=DEF_PAT, history=0, fill=0, seq_det=0 and match_cnt=0.
REQ-029 A reset asserted mid-pattern SHALL discard partial history; no match may complete using pre-reset bits.

Structure
REQ-030 Package seq_det_pkg SHALL hold the default PAT_W, CNT_W and DEF_PAT constants and a function computing the fill width.
REQ-031 The saturating counter with clear SHALL be sub-module seq_match_counter, parametrised by CNT_W.
REQ-032 Illegal PAT_W or CNT_W values SHALL be rejected at elaboration.

Verification
REQ-033 Defaults, overlap=1, stream 1010101 -> seq_det pulses after bits 5 and 7; match_cnt=2.
REQ-034 Defaults, overlap=0, stream 1010101 -> single pulse after bit 5; match_cnt=1; fill=2 at end.
REQ-035 Stream 1,0, then din_vld=0 for 3 cycles with din toggling, then 1,0,1 -> one pulse after the last bit; no pulse during gaps.
REQ-036 After 1101 is received, pat_load with 11011, then 1 -> no pulse and fill=1; then 1011 -> pulse; match_cnt unchanged by the load.
REQ-037 CNT_W=2, four overlapping matches -> match_cnt=3; then cnt_clr on a match edge -> match_cnt=1.
REQ-038 Load 11011, receive 1101, rst_n=0 for one cycle, then 1 -> no pulse; pattern reverts to 10101; all outputs 0 after reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared constants and helpers for the parametrised serial
//               sequence detector. It holds the default pattern length, the
//               default counter width, the default reset pattern, and the
//               function that sizes the fill-level register.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  localparam int          PAT_W_DEF   = 5;
  localparam int          CNT_W_DEF   = 8;
  localparam logic [4:0]  DEF_PAT_DEF = 5'b10101;

  // Width needed to hold a fill level from 0 up to and including pat_w.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_match_counter.sv
`default_nettype none
// ============================================================================
// Module      : seq_match_counter
// Description : Saturating match counter with a synchronous clear. When clear
//               and increment occur on the same edge, the count becomes 1.
//               The counter holds at all-ones and never wraps.
// Ports       : clk_i   - clock
//               rst_ni  - synchronous active-low reset
//               clr_i   - clear strobe
//               inc_i   - increment strobe (one match)
//               cnt_o   - registered count, CNT_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module seq_match_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      // A match on the clearing edge still counts.
      cnt_d = inc_i ? c_CNT_ONE : '0;
    end else if (inc_i && (cnt_q != c_CNT_MAX)) begin
      cnt_d = cnt_q + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : seq_match_counter
`default_nettype wire

// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Parametrised serial pattern detector. Valid input bits shift
//               into a history register. A match occurs when the history is
//               full and equals the programmable pattern. The detector
//               supports overlapping and non-overlapping detection, a
//               runtime pattern load, and a saturating match counter.
// Ports       : fsm_clk   - clock
//               rst_n     - synchronous active-low reset
//               din       - serial data bit
//               din_vld   - din qualifier
//               overlap   - 1 = overlapping detection, 0 = non-overlapping
//               pat_load  - strobe: load pat_in, clear history/fill
//               pat_in    - new pattern (MSB received first)
//               cnt_clr   - strobe: clear match_cnt
//               seq_det   - registered one-cycle detection pulse
//               match_cnt - registered saturating match count
//               fill      - registered number of valid history bits
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = PAT_W_DEF,
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_DEF)
) (
  input  logic                        fsm_clk,
  input  logic                        rst_n,
  input  logic                        din,
  input  logic                        din_vld,
  input  logic                        overlap,
  input  logic                        pat_load,
  input  logic [PAT_W-1:0]            pat_in,
  input  logic                        cnt_clr,
  output logic                        seq_det,
  output logic [CNT_W-1:0]            match_cnt,
  output logic [fill_w(PAT_W)-1:0]    fill
);

  localparam int                  FILL_W      = fill_w(PAT_W);
  localparam logic [FILL_W-1:0]   c_FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0]   c_FILL_ONE  = FILL_W'(1);

  // Parameter legality checks, evaluated at elaboration.
  if ((PAT_W < 2) || (PAT_W > 16)) begin : g_bad_pat_w
    $error("seq_detect_param: PAT_W=%0d outside legal range 2..16", PAT_W);
  end
  if ((CNT_W < 1) || (CNT_W > 16)) begin : g_bad_cnt_w
    $error("seq_detect_param: CNT_W=%0d outside legal range 1..16", CNT_W);
  end

  logic [PAT_W-1:0]  pat_q,  pat_d;
  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              det_q,  det_d;

  logic [PAT_W-1:0]  w_hist_shift;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_match;

  // The shifted history and the saturated fill are the post-shift values.
  // The match decision is made on these values, so the pulse lines up with
  // the edge that samples the final pattern bit.
  assign w_hist_shift = {hist_q[PAT_W-2:0], din};
  assign w_fill_inc   = (fill_q == c_FILL_FULL) ? fill_q : (fill_q + c_FILL_ONE);

  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    w_match = 1'b0;
    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (din_vld) begin
      w_match = (w_fill_inc == c_FILL_FULL) && (w_hist_shift == pat_q);
      hist_d  = w_hist_shift;
      // Non-overlapping mode restarts the fill level, so the next match
      // must be built entirely from fresh bits.
      fill_d  = (w_match && !overlap) ? '0 : w_fill_inc;
      det_d   = w_match;
    end
  end

  always_ff @(posedge fsm_clk) begin
    if (!rst_n) begin
      pat_q  <= DEF_PAT;
      hist_q <= '0;
      fill_q <= '0;
      det_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      det_q  <= det_d;
    end
  end

  seq_match_counter #(
    .CNT_W (CNT_W)
  ) u_match_counter (
    .clk_i  (fsm_clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr),
    .inc_i  (w_match),
    .cnt_o  (match_cnt)
  );

  assign seq_det = det_q;
  assign fill    = fill_q;

endmodule : seq_detect_param
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_param
// Description : Scoreboard bench for seq_detect_param. Each driven cycle
//               pushes its hand-computed expected outputs into a queue. A
//               monitor pops and compares the outputs just after every
//               active edge. A second instance with CNT_W=2 shares the
//               stimulus and exercises counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

  typedef struct {
    int   id;
    logic det;
    int   fill;
    int   cnt;
    int   cnt2;
  } exp_t;

  logic       fsm_clk;
  logic       rst_n;
  logic       din;
  logic       din_vld;
  logic       overlap;
  logic       pat_load;
  logic [4:0] pat_in;
  logic       cnt_clr;

  logic       seq_det_a,  seq_det_b;
  logic [7:0] match_cnt_a;
  logic [1:0] match_cnt_b;
  logic [2:0] fill_a,     fill_b;

  exp_t       exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         step_id  = 0;
  logic       ov_sel   = 1'b1;

  seq_detect_param dut (
    .fsm_clk   (fsm_clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .seq_det   (seq_det_a),
    .match_cnt (match_cnt_a),
    .fill      (fill_a)
  );

  seq_detect_param #(
    .CNT_W (2)
  ) dut_c2 (
    .fsm_clk   (fsm_clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_vld   (din_vld),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .cnt_clr   (cnt_clr),
    .seq_det   (seq_det_b),
    .match_cnt (match_cnt_b),
    .fill      (fill_b)
  );

  initial begin
    fsm_clk = 1'b0;
    forever #5 fsm_clk = ~fsm_clk;
  end

  task automatic chk(input string name, input int id, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  // Monitor: compares outputs just after each edge that had stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge fsm_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("seq_det",      e.id, int'(seq_det_a),   int'(e.det));
        chk("fill",         e.id, int'(fill_a),      e.fill);
        chk("match_cnt",    e.id, int'(match_cnt_a), e.cnt);
        chk("match_cnt_w2", e.id, int'(match_cnt_b), e.cnt2);
        chk("seq_det_w2",   e.id, int'(seq_det_b),   int'(e.det));
      end
    end
  end

  // One cycle of stimulus plus its expected post-edge outputs.
  // The CNT_W=2 instance saturates at 3 and is cleared together with the
  // main instance, so its count is always min(count, 3).
  task automatic step(input logic r, input logic ld, input logic clr,
                      input logic vld, input logic d, input logic [4:0] p,
                      input logic edet, input int efill, input int ecnt);
    exp_t e;
    @(negedge fsm_clk);
    rst_n    = r;
    pat_load = ld;
    cnt_clr  = clr;
    din_vld  = vld;
    din      = d;
    pat_in   = p;
    overlap  = ov_sel;
    step_id++;
    e.id   = step_id;
    e.det  = edet;
    e.fill = efill;
    e.cnt  = ecnt;
    e.cnt2 = (ecnt > 3) ? 3 : ecnt;
    exp_q.push_back(e);
  endtask

  task automatic bitv(input logic d, input logic edet, input int efill, input int ecnt);
    step(1'b1, 1'b0, 1'b0, 1'b1, d, 5'b0, edet, efill, ecnt);
  endtask

  task automatic idle(input logic d, input int efill, input int ecnt);
    step(1'b1, 1'b0, 1'b0, 1'b0, d, 5'b0, 1'b0, efill, ecnt);
  endtask

  // Loads with din_vld=1 and din=1 to show that the load takes priority.
  task automatic load(input logic [4:0] p, input int ecnt);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, p, 1'b0, 0, ecnt);
  endtask

  initial begin
    rst_n    = 1'b0;
    din      = 1'b0;
    din_vld  = 1'b0;
    overlap  = 1'b1;
    pat_load = 1'b0;
    pat_in   = 5'b0;
    cnt_clr  = 1'b0;

    // Reset state.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b0, 1'b0, 0, 0);

    // Overlapping, 1010101: pulses after bits 5 and 7.
    ov_sel = 1'b1;
    bitv(1, 0, 1, 0); bitv(0, 0, 2, 0); bitv(1, 0, 3, 0); bitv(0, 0, 4, 0);
    bitv(1, 1, 5, 1); bitv(0, 0, 5, 1); bitv(1, 1, 5, 2);

    // Load plus clear on the same edge.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b10101, 1'b0, 0, 0);

    // Non-overlapping, 1010101: single pulse, fill ends at 2.
    ov_sel = 1'b0;
    bitv(1, 0, 1, 0); bitv(0, 0, 2, 0); bitv(1, 0, 3, 0); bitv(0, 0, 4, 0);
    bitv(1, 1, 0, 1); bitv(0, 0, 1, 1); bitv(1, 0, 2, 1);

    // Gaps with din toggling are ignored.
    ov_sel = 1'b1;
    load(5'b10101, 1);
    bitv(1, 0, 1, 1); bitv(0, 0, 2, 1);
    idle(1, 2, 1); idle(0, 2, 1); idle(1, 2, 1);
    bitv(1, 0, 3, 1); bitv(0, 0, 4, 1); bitv(1, 1, 5, 2);

    // Pattern reload discards the partial history and leaves the count.
    load(5'b10101, 2);
    bitv(1, 0, 1, 2); bitv(1, 0, 2, 2); bitv(0, 0, 3, 2); bitv(1, 0, 4, 2);
    load(5'b11011, 2);
    bitv(1, 0, 1, 2);
    bitv(1, 0, 2, 2); bitv(0, 0, 3, 2); bitv(1, 0, 4, 2); bitv(1, 1, 5, 3);

    // Mid-pattern reset wins over a simultaneous load and restores DEF_PAT.
    load(5'b11011, 3);
    bitv(1, 0, 1, 3); bitv(1, 0, 2, 3); bitv(0, 0, 3, 3); bitv(1, 0, 4, 3);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11111, 1'b0, 0, 0);
    bitv(1, 0, 1, 0);
    bitv(0, 0, 2, 0); bitv(1, 0, 3, 0); bitv(0, 0, 4, 0); bitv(1, 1, 5, 1);

    // Overlapping chain: the 2-bit counter saturates at 3.
    bitv(0, 0, 5, 1); bitv(1, 1, 5, 2);
    bitv(0, 0, 5, 2); bitv(1, 1, 5, 3);
    bitv(0, 0, 5, 3); bitv(1, 1, 5, 4);
    bitv(0, 0, 5, 4);
    // Clear coinciding with a match leaves a count of 1.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'b0, 1'b1, 5, 1);
    // Clear alone.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'b0, 1'b0, 5, 0);

    // Mode change takes effect on the current edge.
    ov_sel = 1'b0;
    bitv(0, 0, 5, 0); bitv(1, 1, 0, 1);
    ov_sel = 1'b1;
    bitv(1, 0, 1, 1);

    // Drain the scoreboard with a bounded wait.
    begin
      int budget;
      budget = 20;
      while ((exp_q.size() > 0) && (budget > 0)) begin
        @(negedge fsm_clk);
        budget--;
      end
      if (exp_q.size() > 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_seq_detect_param
`default_nettype wire
